// File: rtl/debounce_pkg.sv
// Shared definitions for the time-shared debounce scheduler: FSM encodings,
// the default qualification window and the abort-counter width.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // 10 ms of stable level at a 25 MHz clock.
  localparam int DEFAULT_COUNTER_LIMIT = 250000;

  localparam int ABORT_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Multi-bit two-flop synchronizer for slow, independent level inputs such as
// switches. Each bit is synchronized on its own, so bits are not coherent.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep the two stages as two separate flops;
  // a blocking meta = i_d would collapse them into a single stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= '0;
      o_q  <= '0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces NUM_SW switches with one shared counter, granted round-robin to
// whichever input disagrees with its debounced level. Define
// DEBOUNCE_SCHED_ABORT_CNT_EN to add a saturating abort counter output.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int NUM_SW        = 4,
  parameter int COUNTER_LIMIT = DEFAULT_COUNTER_LIMIT,
  parameter int CNT_W         = 18,
  parameter int IDX_W         = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_SW-1:0] i_switch,
  output logic [NUM_SW-1:0] o_switch,
  output logic              o_change,
  output logic [IDX_W-1:0]  o_change_idx,
`ifdef DEBOUNCE_SCHED_ABORT_CNT_EN
  output logic [ABORT_CNT_W-1:0] o_abort_cnt,
`endif
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTER_LIMIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SW - 1);

  logic [NUM_SW-1:0] sync;
  logic [NUM_SW-1:0] mismatch;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic              target;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  idx_next;

  sync_2ff #(.WIDTH(NUM_SW)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_switch),
    .o_q   (sync)
  );

  assign mismatch = sync ^ o_switch;
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // First mismatching input at or after ptr, wrapping at NUM_SW.
  always_comb begin
    // NOTE: giving pick_idx a value before the loop keeps every path assigned,
    // so no latch is inferred when no bit matches.
    pick_idx = ptr;
    for (int k = NUM_SW - 1; k >= 0; k--) begin
      if (mismatch[(int'(ptr) + k) % NUM_SW]) begin
        pick_idx = IDX_W'((int'(ptr) + k) % NUM_SW);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ptr          <= '0;
      idx          <= '0;
      target       <= 1'b0;
      o_switch     <= '0;
      o_change     <= 1'b0;
      o_change_idx <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_change <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|mismatch) begin
            idx    <= pick_idx;
            target <= sync[pick_idx];
            cnt    <= '0;
            state  <= ST_COUNT;
            o_busy <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (sync[idx] != target) begin
            cnt    <= '0;
            ptr    <= idx_next;
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_COMMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          o_switch[idx] <= target;
          o_change      <= 1'b1;
          o_change_idx  <= idx;
          ptr           <= idx_next;
          state         <= ST_IDLE;
          o_busy        <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_SCHED_ABORT_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_abort_cnt <= '0;
    end else if (state == ST_COUNT && sync[idx] != target && o_abort_cnt != '1) begin
      o_abort_cnt <= o_abort_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with NUM_SW=4, COUNTER_LIMIT=8.
module tb_debounce_scheduler;
  import debounce_pkg::*;

  localparam int NUM_SW = 4;
  localparam int LIMIT  = 8;
  localparam int LAT    = LIMIT + 4;  // drive negedge -> o_change seen at negedge
  localparam int GAP    = LIMIT + 2;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [NUM_SW-1:0] i_switch = '0;
  logic [NUM_SW-1:0] o_switch;
  logic              o_change;
  logic [1:0]        o_change_idx;
  logic              o_busy;
`ifdef DEBOUNCE_SCHED_ABORT_CNT_EN
  logic [ABORT_CNT_W-1:0] o_abort_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_chg  = 0;
  int n_busy = 0;
  int chg_idx [64];
  int chg_cyc [64];

  debounce_scheduler #(
    .NUM_SW(NUM_SW), .COUNTER_LIMIT(LIMIT), .CNT_W(4), .IDX_W(2)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_switch     (i_switch),
    .o_switch     (o_switch),
    .o_change     (o_change),
    .o_change_idx (o_change_idx),
`ifdef DEBOUNCE_SCHED_ABORT_CNT_EN
    .o_abort_cnt  (o_abort_cnt),
`endif
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_busy) n_busy <= n_busy + 1;
    if (o_change) begin
      if (n_chg < 64) begin
        chg_idx[n_chg] <= int'(o_change_idx);
        chg_cyc[n_chg] <= cyc;
      end
      n_chg <= n_chg + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick(2);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    int base_chg, base_busy;
    i_switch = '0;
    do_reset();
    checks++;
    if (o_switch !== 4'b0000 || o_change !== 1'b0 || o_change_idx !== 2'd0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: sw=%b chg=%b idx=%0d busy=%b, required 0000/0/0/0",
               o_switch, o_change, o_change_idx, o_busy);
    end
    base_chg  = n_chg;
    base_busy = n_busy;
    tick(50);
    checks++;
    if (n_chg != base_chg || n_busy != base_busy || o_switch !== 4'b0000) begin
      errors++;
      $display("FAIL idle_hold: changes=%0d busy_cycles=%0d sw=%b, required 0/0/0000",
               n_chg - base_chg, n_busy - base_busy, o_switch);
    end
  endtask

  task automatic test_clean_rise();
    int base, t0;
    base = n_chg;
    i_switch[2] = 1'b1;
    t0 = cyc;
    tick(3);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rise_busy: busy=%b, required 1", o_busy);
    end
    tick(LAT - 4);
    checks++;
    if (o_switch !== 4'b0000) begin
      errors++;
      $display("FAIL rise_early: sw=%b one cycle before commit, required 0000", o_switch);
    end
    tick(1);
    checks++;
    if (o_switch !== 4'b0100 || o_change !== 1'b1 || o_change_idx !== 2'd2) begin
      errors++;
      $display("FAIL rise_commit: sw=%b chg=%b idx=%0d, required 0100/1/2",
               o_switch, o_change, o_change_idx);
    end
    tick(1);
    checks++;
    if (o_change !== 1'b0 || o_busy !== 1'b0 || n_chg - base != 1 || chg_cyc[base] != t0 + LAT) begin
      errors++;
      $display("FAIL rise_pulse: chg=%b busy=%b pulses=%0d at=%0d, required 0/0/1/%0d",
               o_change, o_busy, n_chg - base, chg_cyc[base] - t0, LAT);
    end
  endtask

  task automatic test_bounce();
    int base, t0;
    i_switch = '0;
    do_reset();
    base = n_chg;
    for (int i = 0; i < 10; i++) begin
      i_switch[1] = ~i_switch[1];
      tick(3);
    end
    checks++;
    if (n_chg != base || o_switch !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_quiet: changes=%0d sw=%b during bounce, required 0/0000",
               n_chg - base, o_switch);
    end
    i_switch[1] = 1'b1;
    t0 = cyc;
    tick(20);
    checks++;
    if (n_chg - base != 1 || chg_idx[base] != 1 || chg_cyc[base] != t0 + LAT || o_switch !== 4'b0010) begin
      errors++;
      $display("FAIL bounce_settle: changes=%0d idx=%0d at=%0d sw=%b, required 1/1/%0d/0010",
               n_chg - base, chg_idx[base], chg_cyc[base] - t0, o_switch, LAT);
    end
`ifdef DEBOUNCE_SCHED_ABORT_CNT_EN
    checks++;
    if (o_abort_cnt !== 8'd5) begin
      errors++;
      $display("FAIL abort_cnt: got %0d, required 5", o_abort_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back(input logic [3:0] val, input string name);
    int base, t0;
    base = n_chg;
    i_switch = val;
    t0 = cyc;
    tick(LAT + GAP + 3);
    checks++;
    if (n_chg - base != 2 || chg_idx[base] != 0 || chg_idx[base+1] != 3) begin
      errors++;
      $display("FAIL %s_order: pulses=%0d idx=%0d,%0d, required 2 pulses idx 0,3",
               name, n_chg - base, chg_idx[base], chg_idx[base+1]);
    end
    checks++;
    if (chg_cyc[base] != t0 + LAT || chg_cyc[base+1] - chg_cyc[base] != GAP) begin
      errors++;
      $display("FAIL %s_timing: first=%0d gap=%0d, required %0d/%0d",
               name, chg_cyc[base] - t0, chg_cyc[base+1] - chg_cyc[base], LAT, GAP);
    end
    checks++;
    if (o_switch !== val) begin
      errors++;
      $display("FAIL %s_final: sw=%b, required %b", name, o_switch, val);
    end
  endtask

  task automatic test_reset_mid_count();
    int base, t0;
    base = n_chg;
    i_switch[1] = 1'b1;
    tick(LIMIT);  // counter now holds 5
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: busy=%b before reset, required 1", o_busy);
    end
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    t0 = cyc;
    checks++;
    if (o_switch !== 4'b0000 || o_busy !== 1'b0 || o_change !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: sw=%b busy=%b chg=%b, required 0000/0/0",
               o_switch, o_busy, o_change);
    end
    tick(LAT + 10);
    checks++;
    if (n_chg - base != 1 || chg_idx[base] != 1 || chg_cyc[base] != t0 + LAT || o_switch !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_requal: pulses=%0d idx=%0d at=%0d sw=%b, required 1/1/%0d/0010",
               n_chg - base, chg_idx[base], chg_cyc[base] - t0, o_switch, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    i_switch = '0;
    do_reset();
    test_back_to_back(4'b1001, "rise_pair");
    test_back_to_back(4'b0000, "fall_pair");
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
Time-shares one debounce counter across NUM_SW raw switch inputs instead of one counter per switch. Each input passes through a 2-FF synchronizer. A round-robin scheduler picks one input whose synchronized value differs from its debounced output and qualifies it over COUNTER_LIMIT stable cycles. A committed change updates the debounced vector and emits a one-cycle change event for downstream logic (LED/UART/game-logic blocks).

Parameters:
NUM_SW, 4, number of switch inputs (>=2)
COUNTER_LIMIT, 250000, consecutive stable cycles required to commit (>=1; 10 ms at 25 MHz)
CNT_W, 18, counter width; must satisfy 2**CNT_W > COUNTER_LIMIT
IDX_W, 2, index width; $clog2(NUM_SW)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_switch  in  NUM_SW  raw asynchronous switch levels
o_switch  out  NUM_SW  debounced switch levels
o_change  out  1  one-cycle pulse when an o_switch bit commits a new value
o_change_idx  out  IDX_W  index of the committed bit; valid while o_change=1, holds last value otherwise
o_busy  out  1  high while the state is COUNT or COMMIT

Behaviour:
- One clock domain, i_clk. i_rst is synchronous, active-high, and has priority over all other logic.
- Reset values: o_switch=0, o_change=0, o_change_idx=0, o_busy=0, sync FFs=0, counter=0, round-robin pointer ptr=0, state=IDLE.
- Synchronizer: sync = i_switch delayed 2 edges. mismatch = sync ^ o_switch.
- IDLE: if mismatch!=0, search indices ptr, ptr+1, … with wrap at NUM_SW and take the first set bit as idx. Latch target=sync[idx], clear counter to 0, go to COUNT. If mismatch==0, stay in IDLE.
- COUNT: each cycle, compare sync[idx] with target.
  - Differs: abort. Clear counter, set ptr=(idx+1) mod NUM_SW, go to IDLE. No output change.
  - Equal and counter==COUNTER_LIMIT-1: go to COMMIT.
  - Equal otherwise: counter+1.
- COMMIT, one cycle: on the exit edge set o_switch[idx]=target, o_change=1, o_change_idx=idx, ptr=(idx+1) mod NUM_SW, and go to IDLE. o_change clears on the next edge.
- Latency, uncontended: o_switch changes COUNTER_LIMIT+3 edges after the edge that first samples the new raw level.
- Back-to-back service: the gap between successive o_change pulses is COUNTER_LIMIT+2 cycles.
- Other mismatching inputs wait; they are not tracked while another input is being counted. Round-robin order guarantees service within NUM_SW qualification windows once an input is stable.
- A mismatch that vanishes while an input waits in IDLE, e.g. a glitch shorter than its turn, produces no event.
- A target bit that reverts to the o_switch value mid-COUNT counts as a difference from target, so it aborts.
- Reset mid-COUNT or mid-COMMIT: abandon the operation. No o_change pulse, and o_switch goes to 0.
- Counter never exceeds COUNTER_LIMIT-1, so no wrap is possible.

Optional Feature:
Macro DEBOUNCE_SCHED_ABORT_CNT_EN.
- Defined: adds output o_abort_cnt (8 bits). It increments on every COUNT abort, saturates at 255, and is cleared by i_rst.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include debounce_pkg:
  - state encodings ST_IDLE=2'd0, ST_COUNT=2'd1, ST_COMMIT=2'd2
  - default COUNTER_LIMIT for a 25 MHz clock
  - ABORT_CNT_W=8
- Sub-module sync_2ff: a NUM_SW-wide two-flop synchronizer with synchronous reset, reused by other input blocks.
- Round-robin search stays inline.

Test Plan (NUM_SW=4, COUNTER_LIMIT=8):
1. Reset, hold i_switch=4'b0000 for 50 cycles -> o_switch=0, o_change never asserted, o_busy=0.
2. Clean rise of i_switch[2] -> o_switch=4'b0100 exactly 11 edges after the sampling edge; o_change pulses one cycle with o_change_idx=2.
3. Toggle i_switch[1] every 3 cycles for 30 cycles, then hold 1 -> exactly one o_change, idx=1, after the final settle; with the macro defined, o_abort_cnt equals the number of aborts (nonzero).
4. i_switch[0] and i_switch[3] rise on the same cycle after reset -> commits in order idx=0 then idx=3, pulses 10 cycles apart, final o_switch=4'b1001.
5. Fairness: after test 4 (ptr=0), drop i_switch[3] and i_switch[0] together -> idx=0 serviced first, then idx=3; no starvation.
6. Raise i_switch[1], assert i_rst for 1 cycle at counter=5 -> no o_change, o_switch=0; after release bit 1 re-qualifies and commits 11 edges after the first post-reset sampling edge.
